// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: fetch/decode/execute sequencer for the 4-bit nibbler ALU.
// Holds the program counter and instruction register and reads instruction
// bytes from a synchronous ROM. It drives the ALU controls, the B-operand
// select and the load enables of the accumulator, flag and output registers.
// Jumps take two bytes. The high address nibble comes from the opcode byte and
// the low byte comes from the following ROM location.
// Optional build macro: NIBBLER_HALT_ON_ILLEGAL_EN. When it is defined, the
// unassigned opcodes stop the sequencer in HALT until reset.
module nibbler_sequencer #(
    parameter int unsigned       PC_W     = 12,
    parameter logic [PC_W-1:0]   RESET_PC = 12'h000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    input  logic            carry_flag,
    input  logic            zero_flag,
    output logic            alu_not_carry_in,
    output logic            alu_mode,
    output logic [3:0]      alu_func,
    output logic [3:0]      imm_out,
    output logic            b_sel,
    output logic            acc_load,
    output logic            carry_load,
    output logic            zero_load,
    output logic            out_load,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_JADDR  = 3'd3,
        S_JLOAD  = 3'd4
`ifdef NIBBLER_HALT_ON_ILLEGAL_EN
        , S_HALT = 3'd5
`endif
    } state_t;

    // Bundle of everything the sequencer drives toward the datapath
    typedef struct packed {
        logic       nci;
        logic       mode;
        logic [3:0] func;
        logic       bsel;
        logic       acc;
        logic       cl;
        logic       zl;
        logic       ol;
    } ctrl_t;

    // ALU passes A through, and nothing loads
    localparam ctrl_t C_IDLE = '{nci: 1'b1, mode: 1'b0, func: 4'b0000, bsel: 1'b0,
                                 acc: 1'b0, cl: 1'b0, zl: 1'b0, ol: 1'b0};
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    // Datapath controls for the EXEC cycle of a given opcode
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = C_IDLE;
        case (op)
            4'h1: begin c.mode = 1'b1; c.func = 4'b1010; c.acc = 1'b1; c.zl = 1'b1; end
            4'h2: begin c.func = 4'b1001; c.acc = 1'b1; c.cl = 1'b1; c.zl = 1'b1; end
            4'h3: begin c.nci = 1'b0; c.func = 4'b0110; c.cl = 1'b1; c.zl = 1'b1; end
            4'h4: begin c.mode = 1'b1; c.func = 4'b0001; c.acc = 1'b1; c.zl = 1'b1; end
            4'h5: begin c.ol = 1'b1; end
            4'h6: begin c.mode = 1'b1; c.func = 4'b1010; c.bsel = 1'b1; c.acc = 1'b1; c.zl = 1'b1; end
            default: c = C_IDLE;
        endcase
        return c;
    endfunction

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [PC_W-1:0] r_rom_addr;
    ctrl_t           r_ctrl;

    logic            w_is_jump;
    logic            w_taken;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_jump_target;

    assign w_is_jump     = (r_ir[7:4] == 4'h8) || (r_ir[7:4] == 4'h9) || (r_ir[7:4] == 4'hA);
    assign w_taken       = (r_ir[7:4] == 4'h8) ||
                           ((r_ir[7:4] == 4'h9) && carry_flag) ||
                           ((r_ir[7:4] == 4'hA) && zero_flag);
    assign w_pc_inc      = r_pc + PC_ONE;
    assign w_jump_target = PC_W'({r_ir[3:0], rom_data});

`ifdef NIBBLER_HALT_ON_ILLEGAL_EN
    logic r_halted;
    logic w_illegal;
    assign w_illegal = (r_ir[7:4] == 4'h7) || (r_ir[7:4] >= 4'hB);
    assign halted    = r_halted;
`else
    assign halted    = 1'b0;
`endif

    // Sequencer FSM; every output is a register set on entry to its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= 8'h00;
            r_rom_addr <= RESET_PC;
            r_ctrl     <= C_IDLE;
`ifdef NIBBLER_HALT_ON_ILLEGAL_EN
            r_halted   <= 1'b0;
`endif
        end else begin
            r_ctrl <= C_IDLE;
            case (r_state)
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= rom_data;
                    r_pc    <= w_pc_inc;
                    r_ctrl  <= decode_ctrl(rom_data[7:4]);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // pc already points past the opcode byte: the address byte or the next opcode
                    r_rom_addr <= r_pc;
                    if (w_is_jump) begin
                        r_state <= S_JADDR;
`ifdef NIBBLER_HALT_ON_ILLEGAL_EN
                    end else if (w_illegal) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
`endif
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_JADDR: begin
                    r_state <= S_JLOAD;
                end
                S_JLOAD: begin
                    if (w_taken) begin
                        r_pc       <= w_jump_target;
                        r_rom_addr <= w_jump_target;
                    end else begin
                        r_pc       <= w_pc_inc;
                        r_rom_addr <= w_pc_inc;
                    end
                    r_state <= S_FETCH;
                end
`ifdef NIBBLER_HALT_ON_ILLEGAL_EN
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif
                default: begin
                    r_state    <= S_FETCH;
                    r_rom_addr <= r_pc;
                end
            endcase
        end
    end

    assign rom_addr         = r_rom_addr;
    assign imm_out          = r_ir[3:0];
    assign alu_not_carry_in = r_ctrl.nci;
    assign alu_mode         = r_ctrl.mode;
    assign alu_func         = r_ctrl.func;
    assign b_sel            = r_ctrl.bsel;
    assign acc_load         = r_ctrl.acc;
    assign carry_load       = r_ctrl.cl;
    assign zero_load        = r_ctrl.zl;
    assign out_load         = r_ctrl.ol;

endmodule
